scr1_pipe_mprf_wb: RTL and testbench
====================================

# scr1_pipe_mprf_wb

Writeback controller on the write side of the multi-port register file. It merges single-cycle EXU results and in-order LSU load returns onto the single MPRF write port, arbitrating and buffering when both arrive together. It tracks outstanding load destinations as a scoreboard for hazard stalls, and bypasses the in-flight write onto the rs1/rs2 read data. It sits between EXU/LSU result paths and `scr1_pipe_mprf`.

## Interface
- `ADDR_W`, default 5: MPRF address width (4 under RVE).
- `XLEN`, default 32: data width.
- `LDQ_DEPTH`, default 2: maximum outstanding loads; power of two, ≥2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `exu_wb_vd`  in  1: EXU result valid; always accepted.
- `exu_wb_addr`  in  ADDR_W: EXU destination register.
- `exu_wb_data`  in  XLEN: EXU result.
- `lsu_issue_vd`  in  1: load issued; its destination is enqueued.
- `lsu_issue_addr`  in  ADDR_W: load destination register.
- `lsu_issue_rdy`  out  1: load queue not full.
- `lsu_wb_vd`  in  1: load data returned, oldest outstanding load first.
- `lsu_wb_data`  in  XLEN: load data.
- `lsu_wb_rdy`  out  1: hold register empty.
- `exu2mprf_w_req`  out  1: MPRF write request.
- `exu2mprf_rd_addr`  out  ADDR_W: MPRF write address.
- `exu2mprf_rd_data`  out  XLEN: MPRF write data.
- `rs1_addr`, `rs2_addr`  in  ADDR_W: operand addresses from decode.
- `mprf_rs1_data`, `mprf_rs2_data`  in  XLEN: raw MPRF read data.
- `rs1_data`, `rs2_data`  out  XLEN: bypassed operand data.
- `rs1_busy`, `rs2_busy`  out  1: operand has a pending load write; decode must stall.

## Operation
- **Load queue.** FIFO of `LDQ_DEPTH` destination addresses.
  - Push on `lsu_issue_vd & lsu_issue_rdy`. `lsu_issue_rdy = ~rst & (count < LDQ_DEPTH)`. A pop in the same cycle does not free a slot.
  - Pop on `lsu_wb_vd & lsu_wb_rdy`. `lsu_wb_vd` with an empty queue is illegal (assertion).
  - Read/write pointers wrap modulo depth. `count` is ADDR-independent and `$clog2(LDQ_DEPTH)+1` bits wide.
- **Hold register.** One entry holding {addr, data, valid}. `lsu_wb_rdy = ~rst & ~hold_vd`.
- **Write arbitration, combinational, fixed priority:**
  1. `exu_wb_vd` writes the EXU result.
  2. Otherwise, if `hold_vd`, write the hold entry and clear it.
  3. Otherwise, if a load return is accepted, write it directly with the queue-head address.
- If an accepted load return loses arbitration to the EXU, it is captured into the hold register.
- **x0 handling.** Any write with address 0 forces `exu2mprf_w_req = 0`. It still consumes its arbitration slot, and its queue entry pops normally.
- **Scoreboard.** `rsN_busy` is set when `rsN_addr != 0` and the address matches any valid queue entry or the valid hold entry.
  - A load written to the MPRF this cycle no longer counts as busy, because the bypass covers it.
  - An EXU write to a busy register (WAW) is illegal (assertion).
- **Bypass.** `rsN_data = (exu2mprf_w_req & rd_addr == rsN_addr) ? rd_data : mprf_rsN_data`. For rsN = 0 the MPRF returns 0, and the bypass never matches because x0 writes are suppressed.

## Timing
- EXU writeback has zero-cycle latency: the MPRF updates at the same edge.
- Load writeback latency:
  - 0 cycles when not contended.
  - Otherwise 1 + the number of consecutive `exu_wb_vd` cycles. Unbounded starvation is allowed; the scoreboard keeps this safe.
- Reset, synchronous:
  - Queue emptied, `count = 0`, `hold_vd = 0`.
  - While `rst` is high: `exu2mprf_w_req = 0`, both rdy outputs 0, both busy outputs 0.
  - `lsu_issue_rdy` and `lsu_wb_rdy` read 1 in the first cycle after `rst` falls.
- Reset during outstanding loads drops them silently.
- A push and a pop in the same cycle keep `count` unchanged and both pointers advance. The full condition persists through that cycle.

## Structure
- Shared package additions:
  - `type_scr1_mprf_addr_e` (ADDR_W wide, RVE-aware).
  - `type_scr1_wb_src_e` {WB_NONE, WB_EXU, WB_HOLD, WB_LSU} for the arbiter select.
  - `SCR1_LDQ_DEPTH` constant.
- One sub-module, `scr1_pipe_ldq`: an address FIFO with per-entry compare outputs for two read ports.
- Arbiter, hold register and bypass live in the top level.

## Test plan
- **EXU only:** `exu_wb` x5 = 0xDEAD_BEEF → `w_req = 1` with addr 5 and data 0xDEADBEEF the same cycle. `rs1_addr = 5` returns 0xDEADBEEF via bypass.
- **Load issue/return:** issue x7, then `rs2_addr = 7` → `rs2_busy = 1`. Return 0x1234 two cycles later with no EXU write → direct write of x7 = 0x1234 that cycle, `rs2_busy = 0`.
- **Collision:** EXU x3 = 0xA and load return for x9 = 0xB in the same cycle → x3 is written, x9 goes to hold, `lsu_wb_rdy = 0`. Next cycle, no EXU write → x9 = 0xB written, `lsu_wb_rdy = 1`.
- **Queue full and wrap:** issue x1 and x2 → `lsu_issue_rdy = 0`. Push and pop in the same cycle while full is rejected. Return both, then issue x4 and x6 → pointers wrap and writes land in order x1, x2, x4, x6.
- **x0 and reset:**
  - Load to x0 returns 0xFF → `w_req = 0` and the queue pops.
  - Assert `rst` with 2 loads outstanding → the cycle after release `count = 0`, both busy outputs 0, `lsu_issue_rdy = 1`.

Source files
------------

// File: rtl/scr1_pipe_mprf_wb_pkg.sv
// Shared types and constants for the MPRF writeback controller.
//   type_scr1_mprf_addr_e : MPRF register address (4 bits under RVE, else 5)
//   type_scr1_wb_src_e    : selects which source drives the MPRF write port
//   SCR1_LDQ_DEPTH        : default number of outstanding loads
package scr1_pipe_mprf_wb_pkg;

`ifdef SCR1_RVE_EXT
    localparam int unsigned SCR1_MPRF_ADDR_W = 4;
`else
    localparam int unsigned SCR1_MPRF_ADDR_W = 5;
`endif
    localparam int unsigned SCR1_XLEN      = 32;
    localparam int unsigned SCR1_LDQ_DEPTH = 2;

    typedef logic [SCR1_MPRF_ADDR_W-1:0] type_scr1_mprf_addr_e;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_EXU  = 2'd1,
        WB_HOLD = 2'd2,
        WB_LSU  = 2'd3
    } type_scr1_wb_src_e;

endpackage

// File: rtl/scr1_pipe_mprf_wb_if.sv
// Result/handshake bundle between the EXU/LSU result paths, the writeback
// controller and the MPRF write port.
//   master : pipeline side (drives results and load issue, sees rdy and write)
//   slave  : writeback controller
interface scr1_pipe_mprf_wb_if
    import scr1_pipe_mprf_wb_pkg::*;
#(
    parameter int unsigned ADDR_W = SCR1_MPRF_ADDR_W,
    parameter int unsigned XLEN   = SCR1_XLEN
);
    logic              exu_wb_vd;
    logic [ADDR_W-1:0] exu_wb_addr;
    logic [XLEN-1:0]   exu_wb_data;
    logic              lsu_issue_vd;
    logic [ADDR_W-1:0] lsu_issue_addr;
    logic              lsu_issue_rdy;
    logic              lsu_wb_vd;
    logic [XLEN-1:0]   lsu_wb_data;
    logic              lsu_wb_rdy;
    logic              exu2mprf_w_req;
    logic [ADDR_W-1:0] exu2mprf_rd_addr;
    logic [XLEN-1:0]   exu2mprf_rd_data;

    modport master (
        output exu_wb_vd, exu_wb_addr, exu_wb_data,
        output lsu_issue_vd, lsu_issue_addr, lsu_wb_vd, lsu_wb_data,
        input  lsu_issue_rdy, lsu_wb_rdy,
        input  exu2mprf_w_req, exu2mprf_rd_addr, exu2mprf_rd_data
    );

    modport slave (
        input  exu_wb_vd, exu_wb_addr, exu_wb_data,
        input  lsu_issue_vd, lsu_issue_addr, lsu_wb_vd, lsu_wb_data,
        output lsu_issue_rdy, lsu_wb_rdy,
        output exu2mprf_w_req, exu2mprf_rd_addr, exu2mprf_rd_data
    );
endinterface

// File: rtl/scr1_pipe_ldq.sv
// In-order FIFO of outstanding load destination addresses with per-entry
// address compares for the two operand read ports and the EXU write port.
//   push/push_addr : enqueue a load destination
//   pop            : retire the oldest entry
//   head_addr      : destination of the oldest entry, head_oh its slot
//   count          : number of valid entries
//   *_hit          : per-slot (valid & address match) vectors
module scr1_pipe_ldq
    import scr1_pipe_mprf_wb_pkg::*;
#(
    parameter int unsigned DEPTH  = SCR1_LDQ_DEPTH,
    parameter int unsigned ADDR_W = SCR1_MPRF_ADDR_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DEPTH-1:0]  head_oh,
    output logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] wd_addr,
    output logic [DEPTH-1:0]  rs1_hit,
    output logic [DEPTH-1:0]  rs2_hit,
    output logic [DEPTH-1:0]  wd_hit
);
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    // Pointers, valid bits and occupancy; pointers wrap since DEPTH is 2^n
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Address storage needs no reset; validity lives in vld_q
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
        end
    end

    assign head_addr = addr_q[rd_ptr];
    assign head_oh   = DEPTH'(1) << rd_ptr;
    assign count     = count_q;

    // Per-entry compares
    always_comb begin
        rs1_hit = '0;
        rs2_hit = '0;
        wd_hit  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rs1_hit[i] = vld_q[i] && (addr_q[i] == rs1_addr);
            rs2_hit[i] = vld_q[i] && (addr_q[i] == rs2_addr);
            wd_hit[i]  = vld_q[i] && (addr_q[i] == wd_addr);
        end
    end
endmodule

// File: rtl/scr1_pipe_mprf_wb.sv
// Writeback controller for the MPRF write port: merges EXU results and
// in-order load returns (EXU first, then the hold entry, then a direct load
// return), tracks outstanding load destinations for decode stalls, and
// bypasses the in-flight write onto the operand read data.
//   clk, rst          : clock, synchronous active-high reset
//   wb_if (slave)     : EXU result, load issue/return, MPRF write port
//   rs1/rs2_addr      : decode operand addresses
//   mprf_rs1/2_data   : raw MPRF read data
//   rs1/rs2_data      : bypassed operand data
//   rs1/rs2_busy      : operand has a pending load write
module scr1_pipe_mprf_wb
    import scr1_pipe_mprf_wb_pkg::*;
#(
    parameter int unsigned ADDR_W    = SCR1_MPRF_ADDR_W,
    parameter int unsigned XLEN      = SCR1_XLEN,
    parameter int unsigned LDQ_DEPTH = SCR1_LDQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    scr1_pipe_mprf_wb_if.slave   wb_if,
    input  logic [ADDR_W-1:0]    rs1_addr,
    input  logic [ADDR_W-1:0]    rs2_addr,
    input  logic [XLEN-1:0]      mprf_rs1_data,
    input  logic [XLEN-1:0]      mprf_rs2_data,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);
    localparam int unsigned CNT_W = $clog2(LDQ_DEPTH) + 1;

    logic [ADDR_W-1:0]    ldq_head;
    logic [LDQ_DEPTH-1:0] ldq_head_oh;
    logic [CNT_W-1:0]     ldq_count;
    logic [LDQ_DEPTH-1:0] rs1_hit, rs2_hit, wd_hit;
    logic [LDQ_DEPTH-1:0] head_excl;

    logic                 hold_vd;
    logic [ADDR_W-1:0]    hold_addr;
    logic [XLEN-1:0]      hold_data;

    logic                 issue_push;
    logic                 lsu_acc;
    logic                 hold_cap;
    logic                 hold_wr;
    type_scr1_wb_src_e    wb_src;
    logic [ADDR_W-1:0]    wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 w_req;

    // A pop in the same cycle does not free a slot: rdy looks only at count
    assign wb_if.lsu_issue_rdy = ~rst & (ldq_count < CNT_W'(LDQ_DEPTH));
    assign wb_if.lsu_wb_rdy    = ~rst & ~hold_vd;
    assign issue_push          = wb_if.lsu_issue_vd & wb_if.lsu_issue_rdy;
    assign lsu_acc             = wb_if.lsu_wb_vd & wb_if.lsu_wb_rdy;

    scr1_pipe_ldq #(
        .DEPTH  (LDQ_DEPTH),
        .ADDR_W (ADDR_W)
    ) i_ldq (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_push),
        .push_addr (wb_if.lsu_issue_addr),
        .pop       (lsu_acc),
        .head_addr (ldq_head),
        .head_oh   (ldq_head_oh),
        .count     (ldq_count),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .wd_addr   (wb_if.exu_wb_addr),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit),
        .wd_hit    (wd_hit)
    );

    // Fixed-priority write port arbitration
    always_comb begin
        wb_src  = WB_NONE;
        wb_addr = '0;
        wb_data = '0;
        if (wb_if.exu_wb_vd) begin
            wb_src  = WB_EXU;
            wb_addr = wb_if.exu_wb_addr;
            wb_data = wb_if.exu_wb_data;
        end else if (hold_vd) begin
            wb_src  = WB_HOLD;
            wb_addr = hold_addr;
            wb_data = hold_data;
        end else if (lsu_acc) begin
            wb_src  = WB_LSU;
            wb_addr = ldq_head;
            wb_data = wb_if.lsu_wb_data;
        end
    end

    // x0 writes consume the slot but never reach the MPRF
    assign w_req                  = ~rst & (wb_src != WB_NONE) & (wb_addr != '0);
    assign wb_if.exu2mprf_w_req   = w_req;
    assign wb_if.exu2mprf_rd_addr = wb_addr;
    assign wb_if.exu2mprf_rd_data = wb_data;

    assign hold_cap = lsu_acc & wb_if.exu_wb_vd;
    assign hold_wr  = (wb_src == WB_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vd <= 1'b0;
        end else if (hold_cap) begin
            hold_vd <= 1'b1;
        end else if (hold_wr) begin
            hold_vd <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (hold_cap) begin
            hold_addr <= ldq_head;
            hold_data <= wb_if.lsu_wb_data;
        end
    end

    // A load landing in the MPRF this cycle is covered by the bypass
    assign head_excl = (wb_src == WB_LSU) ? ldq_head_oh : '0;

    assign rs1_busy = ~rst & (rs1_addr != '0)
                    & ((|(rs1_hit & ~head_excl))
                       | (hold_vd & ~hold_wr & (hold_addr == rs1_addr)));
    assign rs2_busy = ~rst & (rs2_addr != '0)
                    & ((|(rs2_hit & ~head_excl))
                       | (hold_vd & ~hold_wr & (hold_addr == rs2_addr)));

    assign rs1_data = (w_req && (wb_addr == rs1_addr)) ? wb_data : mprf_rs1_data;
    assign rs2_data = (w_req && (wb_addr == rs2_addr)) ? wb_data : mprf_rs2_data;

    // Load returns must correspond to an outstanding load
    a_lsu_wb_empty: assert property (@(posedge clk) disable iff (rst)
        !(wb_if.lsu_wb_vd && (ldq_count == '0)));

    // EXU must not overwrite a register with a pending load (WAW)
    a_exu_waw: assert property (@(posedge clk) disable iff (rst)
        !(wb_if.exu_wb_vd && (wb_if.exu_wb_addr != '0)
          && ((|wd_hit) || (hold_vd && (hold_addr == wb_if.exu_wb_addr)))));
endmodule

// File: tb/tb_scr1_pipe_mprf_wb.sv
// Directed self-checking bench for scr1_pipe_mprf_wb (default parameters).
module tb_scr1_pipe_mprf_wb;
    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] mprf_rs1_data, mprf_rs2_data;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;

    int n_cmp;
    int n_err;

    localparam logic [31:0] RAW1 = 32'h1111_1111;
    localparam logic [31:0] RAW2 = 32'h2222_2222;

    scr1_pipe_mprf_wb_if wb_if ();

    scr1_pipe_mprf_wb dut (
        .clk           (clk),
        .rst           (rst),
        .wb_if         (wb_if.slave),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .mprf_rs1_data (mprf_rs1_data),
        .mprf_rs2_data (mprf_rs2_data),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then clear stimulus
    task automatic tick();
        @(posedge clk);
        #1;
        wb_if.exu_wb_vd      = 1'b0;
        wb_if.exu_wb_addr    = '0;
        wb_if.exu_wb_data    = '0;
        wb_if.lsu_issue_vd   = 1'b0;
        wb_if.lsu_issue_addr = '0;
        wb_if.lsu_wb_vd      = 1'b0;
        wb_if.lsu_wb_data    = '0;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        mprf_rs1_data = RAW1;
        mprf_rs2_data = RAW2;
        tick();

        // Reset held: outputs forced quiet even with activity on inputs
        wb_if.exu_wb_vd = 1'b1; wb_if.exu_wb_addr = 5'd5; wb_if.exu_wb_data = 32'h1;
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd3;
        rs1_addr = 5'd3;
        settle();
        chk("rst_wreq", 32'(wb_if.exu2mprf_w_req), 32'd0);
        chk("rst_issue_rdy", 32'(wb_if.lsu_issue_rdy), 32'd0);
        chk("rst_wb_rdy", 32'(wb_if.lsu_wb_rdy), 32'd0);
        chk("rst_busy1", 32'(rs1_busy), 32'd0);
        tick();
        settle();

        // First cycle out of reset
        tick(); rst = 1'b0;
        settle();
        chk("post_rst_issue_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        chk("post_rst_wb_rdy", 32'(wb_if.lsu_wb_rdy), 32'd1);
        chk("post_rst_wreq", 32'(wb_if.exu2mprf_w_req), 32'd0);
        chk("post_rst_busy1", 32'(rs1_busy), 32'd0);

        // EXU only
        tick();
        wb_if.exu_wb_vd = 1'b1; wb_if.exu_wb_addr = 5'd5; wb_if.exu_wb_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd6;
        settle();
        chk("exu_wreq", 32'(wb_if.exu2mprf_w_req), 32'd1);
        chk("exu_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd5);
        chk("exu_data", wb_if.exu2mprf_rd_data, 32'hDEAD_BEEF);
        chk("exu_byp_rs1", rs1_data, 32'hDEAD_BEEF);
        chk("exu_nobyp_rs2", rs2_data, RAW2);

        // Load issue x7 then return with no contention
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd7;
        rs2_addr = 5'd7;
        settle();
        chk("ld_issue_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        tick();
        settle();
        chk("ld_busy", 32'(rs2_busy), 32'd1);
        chk("ld_wreq_idle", 32'(wb_if.exu2mprf_w_req), 32'd0);
        tick();
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'h1234;
        settle();
        chk("ld_wreq", 32'(wb_if.exu2mprf_w_req), 32'd1);
        chk("ld_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd7);
        chk("ld_data", wb_if.exu2mprf_rd_data, 32'h1234);
        chk("ld_busy_clr", 32'(rs2_busy), 32'd0);
        chk("ld_byp_rs2", rs2_data, 32'h1234);
        tick();
        settle();
        chk("ld_busy_after", 32'(rs2_busy), 32'd0);

        // Collision: EXU x3 and load return x9 together
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd9;
        tick();
        wb_if.exu_wb_vd = 1'b1; wb_if.exu_wb_addr = 5'd3; wb_if.exu_wb_data = 32'hA;
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'hB;
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        settle();
        chk("col_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd3);
        chk("col_data", wb_if.exu2mprf_rd_data, 32'hA);
        chk("col_busy9", 32'(rs1_busy), 32'd1);
        chk("col_byp3", rs2_data, 32'hA);
        tick();
        settle();
        chk("hold_wb_rdy", 32'(wb_if.lsu_wb_rdy), 32'd0);
        chk("hold_wreq", 32'(wb_if.exu2mprf_w_req), 32'd1);
        chk("hold_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd9);
        chk("hold_data", wb_if.exu2mprf_rd_data, 32'hB);
        chk("hold_busy_clr", 32'(rs1_busy), 32'd0);
        chk("hold_byp", rs1_data, 32'hB);
        tick();
        settle();
        chk("hold_drained_rdy", 32'(wb_if.lsu_wb_rdy), 32'd1);
        chk("hold_drained_wreq", 32'(wb_if.exu2mprf_w_req), 32'd0);

        // Queue full, push rejected during pop, then wrap
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd1;
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd2;
        settle();
        chk("fill_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd4;
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'h11;
        rs1_addr = 5'd4; rs2_addr = 5'd2;
        settle();
        chk("full_rdy", 32'(wb_if.lsu_issue_rdy), 32'd0);
        chk("full_pop_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd1);
        chk("full_pop_data", wb_if.exu2mprf_rd_data, 32'h11);
        chk("full_busy2", 32'(rs2_busy), 32'd1);
        tick();
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'h22;
        settle();
        chk("rej_busy4", 32'(rs1_busy), 32'd0);
        chk("ret2_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd2);
        chk("ret2_data", wb_if.exu2mprf_rd_data, 32'h22);
        chk("ret2_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd4;
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd6;
        tick();
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'h44;
        rs1_addr = 5'd6;
        settle();
        chk("wrap4_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd4);
        chk("wrap4_data", wb_if.exu2mprf_rd_data, 32'h44);
        chk("wrap_busy6", 32'(rs1_busy), 32'd1);
        tick();
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'h66;
        settle();
        chk("wrap6_addr", 32'(wb_if.exu2mprf_rd_addr), 32'd6);
        chk("wrap6_data", wb_if.exu2mprf_rd_data, 32'h66);
        chk("wrap6_busy_clr", 32'(rs1_busy), 32'd0);

        // Load to x0: no write, entry still pops
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd0;
        rs1_addr = 5'd0;
        tick();
        wb_if.lsu_wb_vd = 1'b1; wb_if.lsu_wb_data = 32'hFF;
        settle();
        chk("x0_wreq", 32'(wb_if.exu2mprf_w_req), 32'd0);
        chk("x0_rs1", rs1_data, RAW1);
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd8;
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd10;
        settle();
        chk("x0_popped_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        tick();
        rs1_addr = 5'd8; rs2_addr = 5'd10;
        settle();
        chk("two_out_busy1", 32'(rs1_busy), 32'd1);
        chk("two_out_busy2", 32'(rs2_busy), 32'd1);
        chk("two_out_rdy", 32'(wb_if.lsu_issue_rdy), 32'd0);

        // Reset with two loads outstanding
        tick();
        rst = 1'b1;
        settle();
        chk("rst2_busy1", 32'(rs1_busy), 32'd0);
        chk("rst2_issue_rdy", 32'(wb_if.lsu_issue_rdy), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("rel_issue_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        chk("rel_wb_rdy", 32'(wb_if.lsu_wb_rdy), 32'd1);
        chk("rel_busy1", 32'(rs1_busy), 32'd0);
        chk("rel_busy2", 32'(rs2_busy), 32'd0);
        tick();
        wb_if.lsu_issue_vd = 1'b1; wb_if.lsu_issue_addr = 5'd12;
        tick();
        settle();
        chk("rel_count_rdy", 32'(wb_if.lsu_issue_rdy), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
